// File: rtl/cnn_layer_sequencer.sv
// Step controller for the shared CONV/POOL/FLATTEN engine: runs five jobs in order,
// routes the engine's result-memory strobes to the right bank and flags protocol errors.
module cnn_layer_sequencer #(
    parameter int CONV_WORDS = 4096,
    parameter int POOL_WORDS = 1024,
    parameter int FLAT_WORDS = 2048,
    parameter int TIMEOUT    = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ready,
    output logic       busy,
    output logic       eng_start,
    output logic [1:0] eng_mode,
    output logic       eng_ksel,
    input  logic       eng_done,
    input  logic       eng_rd,
    input  logic       eng_wr,
    input  logic       eng_src,
    output logic       crd,
    output logic       cwr,
    output logic [2:0] csel,
    output logic       err,
    output logic [1:0] err_code
);

    localparam int TW = ($clog2(TIMEOUT + 1) > 18) ? $clog2(TIMEOUT + 1) : 18;

    localparam logic [12:0] CONV_EXP = 13'(CONV_WORDS);
    localparam logic [12:0] POOL_EXP = 13'(POOL_WORDS);
    localparam logic [12:0] FLAT_EXP = 13'(FLAT_WORDS);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_L0K0 = 3'b001;
    localparam logic [2:0] SEL_L0K1 = 3'b010;
    localparam logic [2:0] SEL_L1K0 = 3'b011;
    localparam logic [2:0] SEL_L1K1 = 3'b100;
    localparam logic [2:0] SEL_L2   = 3'b101;

    localparam logic [1:0] CODE_COUNT   = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT = 2'b10;
    localparam logic [1:0] CODE_COLLIDE = 2'b11;

    typedef enum logic [1:0] {IDLE, START, RUN, ERR} state_t;

    state_t        state, state_nxt;
    logic [2:0]    job, job_nxt;
    logic [12:0]   wcnt, wcnt_nxt, wcnt_inc;
    logic [TW-1:0] tcnt, tcnt_nxt;
    logic [1:0]    code, code_nxt;
    logic [1:0]    mode;
    logic          ksel;
    logic [12:0]   expected;
    logic          collide;
    logic          gate;

    always_comb begin
        case (job)
            3'd0:    begin mode = 2'd0; ksel = 1'b0; end
            3'd1:    begin mode = 2'd0; ksel = 1'b1; end
            3'd2:    begin mode = 2'd1; ksel = 1'b0; end
            3'd3:    begin mode = 2'd1; ksel = 1'b1; end
            default: begin mode = 2'd2; ksel = 1'b0; end
        endcase
        case (mode)
            2'd0:    expected = CONV_EXP;
            2'd1:    expected = POOL_EXP;
            default: expected = FLAT_EXP;
        endcase
    end

    // A simultaneous read and write is blocked in the same cycle it appears.
    assign collide = (state == RUN) && eng_rd && eng_wr;
    assign gate    = (state == RUN) && !collide;
    assign crd     = gate && eng_rd;
    assign cwr     = gate && eng_wr;

    always_comb begin
        csel = SEL_NONE;
        if (gate && eng_wr) begin
            case (mode)
                2'd0:    csel = ksel ? SEL_L0K1 : SEL_L0K0;
                2'd1:    csel = ksel ? SEL_L1K1 : SEL_L1K0;
                default: csel = SEL_L2;
            endcase
        end else if (gate && eng_rd) begin
            case (mode)
                2'd0:    csel = SEL_NONE;
                2'd1:    csel = ksel ? SEL_L0K1 : SEL_L0K0;
                default: csel = eng_src ? SEL_L1K1 : SEL_L1K0;
            endcase
        end
    end

    assign wcnt_inc = (cwr && wcnt != 13'h1fff) ? wcnt + 13'd1 : wcnt;

    // NOTE: every output of this block gets a default first so no path leaves a latch.
    always_comb begin
        state_nxt = state;
        job_nxt   = job;
        wcnt_nxt  = wcnt;
        tcnt_nxt  = tcnt;
        code_nxt  = code;
        eng_start = 1'b0;
        case (state)
            IDLE: begin
                if (ready) begin
                    state_nxt = START;
                    job_nxt   = 3'd0;
                end
            end
            START: begin
                eng_start = 1'b1;
                wcnt_nxt  = '0;
                tcnt_nxt  = '0;
                state_nxt = RUN;
            end
            RUN: begin
                wcnt_nxt = wcnt_inc;
                tcnt_nxt = tcnt + TW'(1);
                if (collide) begin
                    state_nxt = ERR;
                    code_nxt  = CODE_COLLIDE;
                end else if (eng_done) begin
                    if (wcnt_inc != expected) begin
                        state_nxt = ERR;
                        code_nxt  = CODE_COUNT;
                    end else if (job == 3'd4) begin
                        state_nxt = IDLE;
                        job_nxt   = 3'd0;
                    end else begin
                        state_nxt = START;
                        job_nxt   = job + 3'd1;
                    end
                end else if (tcnt == TMO_LAST) begin
                    state_nxt = ERR;
                    code_nxt  = CODE_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            job   <= '0;
            wcnt  <= '0;
            tcnt  <= '0;
            code  <= '0;
        end else begin
            state <= state_nxt;
            job   <= job_nxt;
            wcnt  <= wcnt_nxt;
            tcnt  <= tcnt_nxt;
            code  <= code_nxt;
        end
    end

    assign busy     = (state == START) || (state == RUN);
    assign eng_mode = busy ? mode : 2'd0;
    assign eng_ksel = busy && ksel;
    assign err      = (state == ERR);
    assign err_code = code;

endmodule
